// File: rtl/pe_uno_seq.sv
// pe_uno_seq: drives one PE in unary mode through a Horner MAC chain.
// Per-op coefficient/length tables, one operand per request, valid/ready result.
module pe_uno_seq #(
    parameter int MUL_BW   = 16,
    parameter int ACC_BW   = 32,
    parameter int NUM_COEF = 8,
    localparam int IW      = $clog2(NUM_COEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [MUL_BW-1:0] req_x,
    input  logic              cfg_we,
    input  logic              cfg_len,
    input  logic [1:0]        cfg_op,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [MUL_BW-1:0] cfg_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_BW-1:0] res_data,
    output logic              res_err,
    output logic [1:0]        pe_gemm_uno,
    output logic [ACC_BW-1:0] pe_mac_o,
    output logic [MUL_BW-1:0] pe_var_o,
    output logic [MUL_BW-1:0] pe_wc_o,
    input  logic [ACC_BW-1:0] pe_mac_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [IW:0] LEN_MAX = (IW+1)'(NUM_COEF);
    localparam logic [IW:0] ONE     = (IW+1)'(1);
    localparam logic [IW:0] TWO     = (IW+1)'(2);

    logic [2:0]        state_q;
    logic [1:0]        op_q;
    logic [MUL_BW-1:0] x_q;
    logic [IW:0]       l_q;
    logic [IW:0]       r_q;

    // op 0 rows exist only so op_q/cfg_op index without offset
    logic [MUL_BW-1:0] coef_q [4][NUM_COEF];
    logic [IW:0]       len_q  [4];

    logic              accept;
    logic              cfg_ok;
    logic              idx_ok;
    logic [IW:0]       len_acc;
    logic              bad_req;
    logic [IW-1:0]     ld_idx;
    logic [IW-1:0]     run_idx;
    logic [IW-1:0]     seed_idx;

    assign req_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_RESP);
    assign accept    = req_valid & req_ready;
    assign cfg_ok    = cfg_we && (state_q == S_IDLE) && (cfg_op != 2'b00);
    assign idx_ok    = (32'(cfg_idx) < 32'(NUM_COEF));

    // a length written on the accept edge is already the one the request uses
    assign len_acc = (cfg_ok && cfg_len && (cfg_op == req_op))
                   ? cfg_data[IW:0] : len_q[req_op];

    assign bad_req = (req_op == 2'b00) || (len_acc < TWO) || (len_acc > LEN_MAX);

    assign ld_idx   = IW'(l_q - TWO);
    assign run_idx  = IW'(l_q - TWO - r_q);
    assign seed_idx = IW'(l_q - ONE);

    // coefficient and length tables, writable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < 4; o++) begin
                len_q[o] <= LEN_MAX;
                for (int k = 0; k < NUM_COEF; k++) begin
                    coef_q[o][k] <= '0;
                end
            end
        end else if (cfg_ok) begin
            if (cfg_len) begin
                len_q[cfg_op] <= cfg_data[IW:0];
            end else if (idx_ok) begin
                coef_q[cfg_op][cfg_idx] <= cfg_data;
            end
        end
    end

    // sequencer: accept, step the PE L-1 times, capture, hand off result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            x_q      <= '0;
            l_q      <= '0;
            r_q      <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= req_op;
                        x_q  <= req_x;
                        l_q  <= len_acc;
                        r_q  <= ONE;
                        if (bad_req) begin
                            res_err  <= 1'b1;
                            res_data <= '0;
                            state_q  <= S_RESP;
                        end else begin
                            state_q  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: state_q <= S_RUN;
                S_RUN: begin
                    if (r_q == l_q - ONE) begin
                        state_q <= S_CAPT;
                    end else begin
                        r_q <= r_q + ONE;
                    end
                end
                S_CAPT: begin
                    res_data <= pe_mac_i;
                    res_err  <= 1'b0;
                    state_q  <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // PE drive: mode, coefficient, operand and accumulator feedback per state
    always_comb begin
        pe_gemm_uno = 2'b00;
        pe_mac_o    = '0;
        pe_var_o    = '0;
        pe_wc_o     = '0;
        unique case (state_q)
            S_LOAD: begin
                pe_gemm_uno = op_q;
                pe_wc_o     = coef_q[op_q][ld_idx];
                pe_var_o    = x_q;
            end
            S_RUN: begin
                pe_gemm_uno = op_q;
                pe_var_o    = x_q;
                if (r_q == ONE) begin
                    pe_mac_o = {coef_q[op_q][seed_idx],
                                {(ACC_BW-MUL_BW){1'b0}}};
                end else begin
                    pe_mac_o = pe_mac_i;
                end
                if (r_q < l_q - ONE) begin
                    pe_wc_o = coef_q[op_q][run_idx];
                end
            end
            S_CAPT: pe_gemm_uno = op_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pe_uno_seq.sv
// tb_pe_uno_seq: scoreboard bench for pe_uno_seq with a behavioural PE.
// Expected results come from a Horner reference over a shadow coef table.
module tb_pe_uno_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_x;
    logic        cfg_we;
    logic        cfg_len;
    logic [1:0]  cfg_op;
    logic [2:0]  cfg_idx;
    logic [15:0] cfg_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic [1:0]  pe_gemm_uno;
    logic [31:0] pe_mac_o;
    logic [15:0] pe_var_o;
    logic [15:0] pe_wc_o;
    logic [31:0] pe_mac_i;

    pe_uno_seq dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_x       (req_x),
        .cfg_we      (cfg_we),
        .cfg_len     (cfg_len),
        .cfg_op      (cfg_op),
        .cfg_idx     (cfg_idx),
        .cfg_data    (cfg_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .pe_gemm_uno (pe_gemm_uno),
        .pe_mac_o    (pe_mac_o),
        .pe_var_o    (pe_var_o),
        .pe_wc_o     (pe_wc_o),
        .pe_mac_i    (pe_mac_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PE: acc <= (mac*var)>>>16 + coef presented one cycle earlier
    logic [15:0]        pe_wc_q = '0;
    logic [31:0]        pe_acc  = '0;
    logic signed [47:0] pe_p;
    assign pe_p = $signed(pe_mac_o) * $signed(pe_var_o);
    always @(posedge clk) begin
        pe_wc_q <= pe_wc_o;
        if (pe_gemm_uno != 2'b00) begin
            pe_acc <= pe_p[47:16] + {{16{pe_wc_q[15]}}, pe_wc_q};
        end
    end
    assign pe_mac_i = pe_acc;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          len;
        int          op;
        logic [15:0] x;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] tb_coef [4][8];
    int          tb_len  [4];
    logic [15:0] wc_log  [16];
    logic [15:0] var_log [16];
    logic [31:0] mac_log [16];
    int          acc_cyc;
    int          n_tot = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_eval(input int op, input int L,
                                             input logic [15:0] x);
        logic signed [31:0] acc;
        logic signed [47:0] p;
        logic [15:0]        c;
        acc = {tb_coef[op][L-1], 16'h0};
        for (int k = L - 2; k >= 0; k--) begin
            p   = acc * $signed(x);
            c   = tb_coef[op][k];
            acc = p[47:16] + {{16{c[15]}}, c};
        end
        return acc;
    endfunction

    task automatic shadow_reset();
        for (int o = 0; o < 4; o++) begin
            tb_len[o] = 8;
            for (int k = 0; k < 8; k++) tb_coef[o][k] = '0;
        end
    endtask

    task automatic cfg_write(input bit is_len, input logic [1:0] op,
                             input int idx, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_len  = is_len;
        cfg_op   = op;
        cfg_idx  = 3'(idx);
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (op != 2'b00) begin
            if (is_len) tb_len[op] = int'(d[3:0]);
            else tb_coef[op][idx] = d;
        end
    endtask

    task automatic send_req(input logic [1:0] op, input logic [15:0] x);
        exp_t e;
        e.op   = int'(op);
        e.len  = (op == 2'b00) ? 0 : tb_len[op];
        e.x    = x;
        e.err  = (op == 2'b00) || (e.len < 2) || (e.len > 8);
        e.data = e.err ? 32'h0 : ref_eval(e.op, e.len, x);
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        chk("req_ready_pre", {31'b0, req_ready}, 32'd1);
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        acc_cyc   = cyc;
        req_valid = 1'b0;
        cfg_we    = 1'b0;
    endtask

    task automatic wait_result(input bit poke);
        exp_t e;
        int   lat;
        int   gn;
        int   n;
        lat = -1;
        gn  = 0;
        n   = 0;
        chk("sb_size", sbq.size(), 32'd1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        for (int i = 0; i < 40; i++) begin
            if (res_valid) begin
                lat = cyc - acc_cyc + 1;
                break;
            end
            if (poke) begin
                if (i == 1) begin
                    cfg_we = 1'b1; cfg_len = 1'b0; cfg_op = 2'b10;
                    cfg_idx = 3'd0; cfg_data = 16'd100;
                end
                if (i == 2) begin
                    cfg_len = 1'b1; cfg_data = 16'd3;
                end
                if (i == 3) cfg_we = 1'b0;
            end
            if (e.op != 0 && pe_gemm_uno == 2'(e.op)) gn++;
            if (n < 16) begin
                wc_log[n]  = pe_wc_o;
                var_log[n] = pe_var_o;
                mac_log[n] = pe_mac_o;
                n++;
            end
            @(negedge clk);
        end
        chk("res_valid_seen", {31'b0, res_valid}, 32'd1);
        chk("latency", lat, e.err ? 32'd1 : 32'(e.len + 2));
        chk("res_data", res_data, e.data);
        chk("res_err", {31'b0, res_err}, {31'b0, e.err});
        if (!e.err) begin
            chk("gemm_cycles", gn, 32'(e.len + 1));
            chk("load_var", {16'h0, var_log[0]}, {16'h0, e.x});
            chk("load_mac", mac_log[0], 32'h0);
            chk("seed", mac_log[1], {tb_coef[e.op][e.len-1], 16'h0});
            for (int k = 0; k < e.len; k++) begin
                chk($sformatf("wc%0d", k), {16'h0, wc_log[k]},
                    (k <= e.len - 2) ? {16'h0, tb_coef[e.op][e.len-2-k]} : 32'h0);
            end
        end
    endtask

    task automatic finish_result();
        res_ready = 1'b1;
        @(negedge clk);
        chk("res_valid_drop", {31'b0, res_valid}, 32'd0);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outs(input string p);
        chk({p, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({p, "_res_valid"}, {31'b0, res_valid}, 32'd0);
        chk({p, "_res_data"}, res_data, 32'h0);
        chk({p, "_res_err"}, {31'b0, res_err}, 32'd0);
        chk({p, "_gemm"}, {30'b0, pe_gemm_uno}, 32'd0);
        chk({p, "_mac"}, pe_mac_o, 32'h0);
        chk({p, "_var"}, {16'h0, pe_var_o}, 32'h0);
        chk({p, "_wc"}, {16'h0, pe_wc_o}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=done");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_x = '0;
        cfg_we = 1'b0; cfg_len = 1'b0; cfg_op = 2'b00; cfg_idx = '0;
        cfg_data = '0; res_ready = 1'b1;
        shadow_reset();
        repeat (2) @(negedge clk);
        chk_reset_outs("rst");
        rst = 1'b0;
        @(negedge clk);

        cfg_write(1'b0, 2'b10, 0, 16'd7);
        cfg_write(1'b0, 2'b10, 1, 16'd3);
        cfg_write(1'b1, 2'b10, 0, 16'd2);
        send_req(2'b10, 16'd5);
        wait_result(1'b0);
        finish_result();

        cfg_write(1'b1, 2'b01, 0, 16'd4);
        for (int k = 0; k < 4; k++) cfg_write(1'b0, 2'b01, k, 16'(k + 1));
        send_req(2'b01, 16'd1);
        wait_result(1'b0);
        finish_result();

        send_req(2'b00, 16'd1);
        wait_result(1'b0);
        finish_result();
        cfg_write(1'b1, 2'b11, 0, 16'd1);
        send_req(2'b11, 16'd4);
        wait_result(1'b0);
        finish_result();
        cfg_write(1'b1, 2'b11, 0, 16'd9);
        send_req(2'b11, 16'd4);
        wait_result(1'b0);
        finish_result();

        cfg_write(1'b1, 2'b11, 0, 16'd8);
        for (int k = 0; k < 8; k++) cfg_write(1'b0, 2'b11, k, 16'(k * 300 - 900));
        send_req(2'b11, 16'hFB2E);
        wait_result(1'b0);
        finish_result();

        cfg_we = 1'b1; cfg_len = 1'b1; cfg_op = 2'b01; cfg_data = 16'd2;
        tb_len[1] = 2;
        send_req(2'b01, 16'd3);
        wait_result(1'b0);
        finish_result();

        res_ready = 1'b0;
        send_req(2'b10, 16'd5);
        wait_result(1'b0);
        req_valid = 1'b1; req_op = 2'b01; req_x = 16'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, res_valid}, 32'd1);
            chk("hold_data", res_data, 32'd22);
            chk("hold_busy", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        finish_result();

        cfg_write(1'b1, 2'b01, 0, 16'd4);
        send_req(2'b01, 16'd1);
        wait_result(1'b1);
        finish_result();
        send_req(2'b10, 16'd5);
        wait_result(1'b0);
        finish_result();

        send_req(2'b01, 16'd2);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outs("abort");
        sbq.delete();
        shadow_reset();
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid) vcnt++;
        end
        chk("abort_no_result", vcnt, 32'd0);
        cfg_write(1'b0, 2'b10, 1, 16'd3);
        cfg_write(1'b1, 2'b10, 0, 16'd2);
        send_req(2'b10, 16'd5);
        wait_result(1'b0);
        finish_result();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
